mem_channel_arbiter: RTL and testbench

// Shares one memory channel (read + write) between NUM_CONSUMERS requesters (LSUs or fetchers).

---
 rtl/states_pkg.sv | 18 +
 rtl/rr_priority_picker.sv | 34 +++
 rtl/mem_channel_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_channel_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/states_pkg.sv
// Controller state encoding shared by memory-channel sequencers, plus a width helper.
// Encodings 3'b001, 3'b110 and 3'b111 are unused and fall back to IDLE.
package states_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'b000,
    READ_WAITING   = 3'b010,
    WRITE_WAITING  = 3'b011,
    READ_RELAYING  = 3'b100,
    WRITE_RELAYING = 3'b101
  } controller_state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first requester at or after ptr, wrapping
// from N-1 back to 0. N need not be a power of two.
module rr_priority_picker
  import states_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_bits(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          grant_valid,
  output logic [PW-1:0] grant_idx
);

  int cand;

  // Walk from the farthest candidate back to ptr so the nearest one wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Shares one read/write memory channel between NUM_CONSUMERS requesters with
// round-robin grants and a single transaction in flight.
module mem_channel_arbiter
  import states_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter bit WRITE_ENABLE  = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int PW = ptr_bits(NUM_CONSUMERS);

  controller_state_t state_reg, state_next;
  logic [PW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [PW-1:0] idx_reg, idx_next;

  logic                               mem_read_valid_reg, mem_read_valid_next;
  logic [ADDR_BITS-1:0]               mem_read_address_reg, mem_read_address_next;
  logic                               mem_write_valid_reg, mem_write_valid_next;
  logic [ADDR_BITS-1:0]               mem_write_address_reg, mem_write_address_next;
  logic [DATA_BITS-1:0]               mem_write_data_reg, mem_write_data_next;
  logic [NUM_CONSUMERS-1:0]           read_ready_reg, read_ready_next;
  logic [NUM_CONSUMERS-1:0]           write_ready_reg, write_ready_next;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_reg, read_data_next;

  logic [NUM_CONSUMERS-1:0] write_req;
  logic [NUM_CONSUMERS-1:0] any_req;
  logic                     grant_valid;
  logic [PW-1:0]            grant_idx;
  logic                     grant_is_read;
  logic [PW-1:0]            ptr_after_idx;

  // Without a write path, write requests never take part in arbitration.
  assign write_req     = WRITE_ENABLE ? consumer_write_valid : '0;
  assign any_req       = consumer_read_valid | write_req;
  assign grant_is_read = consumer_read_valid[grant_idx];
  assign ptr_after_idx = (idx_reg == PW'(NUM_CONSUMERS - 1)) ? '0 : idx_reg + PW'(1);

  rr_priority_picker #(
    .N  (NUM_CONSUMERS),
    .PW (PW)
  ) u_picker (
    .req         (any_req),
    .ptr         (rr_ptr_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          state_next = grant_is_read ? READ_WAITING : WRITE_WAITING;
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) state_next = READ_RELAYING;
      end
      WRITE_WAITING: begin
        if (mem_write_ready) state_next = WRITE_RELAYING;
      end
      READ_RELAYING: begin
        if (!consumer_read_valid[idx_reg]) state_next = IDLE;
      end
      WRITE_RELAYING: begin
        if (!consumer_write_valid[idx_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_next            = rr_ptr_reg;
    idx_next               = idx_reg;
    mem_read_valid_next    = mem_read_valid_reg;
    mem_read_address_next  = mem_read_address_reg;
    mem_write_valid_next   = mem_write_valid_reg;
    mem_write_address_next = mem_write_address_reg;
    mem_write_data_next    = mem_write_data_reg;
    read_ready_next        = read_ready_reg;
    write_ready_next       = write_ready_reg;
    read_data_next         = read_data_reg;
    case (state_reg)
      IDLE: begin
        // Address and data are captured only here; later changes are ignored.
        if (grant_valid) begin
          idx_next = grant_idx;
          if (grant_is_read) begin
            mem_read_valid_next   = 1'b1;
            mem_read_address_next = consumer_read_address[grant_idx*ADDR_BITS +: ADDR_BITS];
          end else begin
            mem_write_valid_next   = 1'b1;
            mem_write_address_next = consumer_write_address[grant_idx*ADDR_BITS +: ADDR_BITS];
            mem_write_data_next    = consumer_write_data[grant_idx*DATA_BITS +: DATA_BITS];
          end
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) begin
          mem_read_valid_next                            = 1'b0;
          read_ready_next[idx_reg]                       = 1'b1;
          read_data_next[idx_reg*DATA_BITS +: DATA_BITS] = mem_read_data;
        end
      end
      WRITE_WAITING: begin
        if (mem_write_ready) begin
          mem_write_valid_next      = 1'b0;
          write_ready_next[idx_reg] = 1'b1;
        end
      end
      READ_RELAYING: begin
        if (!consumer_read_valid[idx_reg]) begin
          read_ready_next = '0;
          rr_ptr_next     = ptr_after_idx;
        end
      end
      WRITE_RELAYING: begin
        if (!consumer_write_valid[idx_reg]) begin
          write_ready_next = '0;
          rr_ptr_next      = ptr_after_idx;
        end
      end
      default: begin
        mem_read_valid_next  = 1'b0;
        mem_write_valid_next = 1'b0;
        read_ready_next      = '0;
        write_ready_next     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg            <= '0;
      idx_reg               <= '0;
      mem_read_valid_reg    <= 1'b0;
      mem_read_address_reg  <= '0;
      mem_write_valid_reg   <= 1'b0;
      mem_write_address_reg <= '0;
      mem_write_data_reg    <= '0;
      read_ready_reg        <= '0;
      write_ready_reg       <= '0;
      read_data_reg         <= '0;
    end else begin
      rr_ptr_reg            <= rr_ptr_next;
      idx_reg               <= idx_next;
      mem_read_valid_reg    <= mem_read_valid_next;
      mem_read_address_reg  <= mem_read_address_next;
      mem_write_valid_reg   <= mem_write_valid_next;
      mem_write_address_reg <= mem_write_address_next;
      mem_write_data_reg    <= mem_write_data_next;
      read_ready_reg        <= read_ready_next;
      write_ready_reg       <= write_ready_next;
      read_data_reg         <= read_data_next;
    end
  end

  assign mem_read_valid       = mem_read_valid_reg;
  assign mem_read_address     = mem_read_address_reg;
  assign mem_write_valid      = mem_write_valid_reg & WRITE_ENABLE;
  assign mem_write_address    = mem_write_address_reg;
  assign mem_write_data       = mem_write_data_reg;
  assign consumer_read_ready  = read_ready_reg;
  assign consumer_write_ready = write_ready_reg & {NUM_CONSUMERS{WRITE_ENABLE}};
  assign consumer_read_data   = read_data_reg;

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Bench for mem_channel_arbiter: a 4-consumer read/write instance driven from a
// vector table, hand sequences and random batches, plus a 3-consumer read-only instance.
module tb_mem_channel_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic       wr;
    logic [2:0] idx;
    logic [7:0] data;
  } rec_t;

  typedef struct packed {
    logic [3:0]      rd;
    logic [3:0]      wr;
    logic [3:0][7:0] ra;
    logic [3:0][7:0] wa;
    logic [3:0][7:0] wd;
    int              lat;
    int              n;
    rec_t [7:0]      exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   consumer_read_valid = '0;
  logic [N*8-1:0] consumer_read_address = '0;
  logic [N-1:0]   consumer_read_ready;
  logic [N*8-1:0] consumer_read_data;
  logic [N-1:0]   consumer_write_valid = '0;
  logic [N*8-1:0] consumer_write_address = '0;
  logic [N*8-1:0] consumer_write_data = '0;
  logic [N-1:0]   consumer_write_ready;
  logic           mem_read_valid;
  logic [7:0]     mem_read_address;
  logic           mem_read_ready = 1'b0;
  logic [7:0]     mem_read_data = '0;
  logic           mem_write_valid;
  logic [7:0]     mem_write_address;
  logic [7:0]     mem_write_data;
  logic           mem_write_ready = 1'b0;

  logic [2:0]  b_crv = '0;
  logic [23:0] b_cra = '0;
  logic [2:0]  b_crr;
  logic [23:0] b_crd;
  logic [2:0]  b_cwv = '0;
  logic [23:0] b_cwa = '0;
  logic [23:0] b_cwd = '0;
  logic [2:0]  b_cwr;
  logic        b_mrv;
  logic [7:0]  b_mra;
  logic        b_mrr = 1'b0;
  logic [7:0]  b_mrd = '0;
  logic        b_mwv;
  logic [7:0]  b_mwa;
  logic [7:0]  b_mwd;
  logic        b_mwr = 1'b1;

  mem_channel_arbiter #(
    .NUM_CONSUMERS(4), .ADDR_BITS(8), .DATA_BITS(8), .WRITE_ENABLE(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
  );

  mem_channel_arbiter #(
    .NUM_CONSUMERS(3), .ADDR_BITS(8), .DATA_BITS(8), .WRITE_ENABLE(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
    .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic rec_t ex(input logic wr, input int idx, input logic [7:0] d);
    rec_t r;
    r.wr   = wr;
    r.idx  = 3'(idx);
    r.data = d;
    return r;
  endfunction

  // External memory for the 4-consumer instance: mem[a] starts as a ^ 0x99.
  logic [7:0] mem_arr [256];
  int mem_lat = 1;
  int rd_cnt  = 0;
  int wr_cnt  = 0;

  initial begin
    for (int a = 0; a < 256; a++) mem_arr[a] = 8'(a) ^ 8'h99;
  end

  always @(negedge clk) begin
    if (reset || !mem_read_valid) begin
      mem_read_ready = 1'b0;
      mem_read_data  = 8'($urandom);
      rd_cnt         = 0;
    end else if (rd_cnt >= mem_lat) begin
      mem_read_ready = 1'b1;
      mem_read_data  = mem_arr[mem_read_address];
    end else begin
      rd_cnt++;
    end
    if (reset || !mem_write_valid) begin
      mem_write_ready = 1'b0;
      wr_cnt          = 0;
    end else if (wr_cnt >= mem_lat) begin
      mem_write_ready = 1'b1;
      mem_arr[mem_write_address] = mem_write_data;
    end else begin
      wr_cnt++;
    end
  end

  // Read-only instance: memory answers in the first waiting cycle.
  always @(negedge clk) begin
    b_mrr = !reset && b_mrv && !b_mrr;
    b_mrd = b_mra ^ 8'h99;
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("mem_valid_exclusive", 32'(mem_read_valid & mem_write_valid), 0);
      chk("ready_onehot0", 32'($onehot0(consumer_read_ready | consumer_write_ready)), 1);
      chk("b_mem_write_valid", 32'(b_mwv), 0);
      chk("b_write_ready", 32'(b_cwr), 0);
    end
  end

  logic [7:0] cur_ra [N];
  logic [7:0] cur_wa [N];
  logic [7:0] cur_wd [N];
  rec_t got_q[$];
  rec_t exp_q[$];

  task automatic run_batch(input logic [3:0] rd, input logic [3:0] wr);
    got_q.delete();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      consumer_read_address[i*8 +: 8]  = cur_ra[i];
      consumer_write_address[i*8 +: 8] = cur_wa[i];
      consumer_write_data[i*8 +: 8]    = cur_wd[i];
    end
    consumer_read_valid  = rd;
    consumer_write_valid = wr;
    for (int c = 0; c < 400 && (consumer_read_valid | consumer_write_valid) != 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (consumer_read_valid[i] && consumer_read_ready[i]) begin
          got_q.push_back(ex(1'b0, i, consumer_read_data[i*8 +: 8]));
          $display("txn c%0d read  addr=%02h data=%02h", i, cur_ra[i], consumer_read_data[i*8 +: 8]);
          consumer_read_valid[i] = 1'b0;
        end
        if (consumer_write_valid[i] && consumer_write_ready[i]) begin
          got_q.push_back(ex(1'b1, i, 8'h00));
          $display("txn c%0d write addr=%02h data=%02h", i, cur_wa[i], cur_wd[i]);
          consumer_write_valid[i] = 1'b0;
        end
      end
    end
    chk("batch_complete", 32'(consumer_read_valid | consumer_write_valid), 0);
    consumer_read_valid  = '0;
    consumer_write_valid = '0;
  endtask

  task automatic compare_q(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      chk({tag, "_order"}, {got_q[k].wr, got_q[k].idx}, {exp_q[k].wr, exp_q[k].idx});
      if (!exp_q[k].wr) chk({tag, "_data"}, got_q[k].data, exp_q[k].data);
    end
  endtask

  int b_order[$];

  task automatic b_serve(input logic [2:0] rd);
    @(negedge clk);
    b_crv = rd;
    for (int c = 0; c < 200 && b_crv != 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (b_crv[i] && b_crr[i]) begin
          b_order.push_back(i);
          $display("txn b c%0d read data=%02h", i, b_crd[i*8 +: 8]);
          chk("b_read_data", b_crd[i*8 +: 8], (8'h40 + 8'(i)) ^ 8'h99);
          b_crv[i] = 1'b0;
        end
      end
    end
    chk("b_batch_complete", 32'(b_crv), 0);
    b_crv = '0;
  endtask

  vec_t vecs[6];
  logic [7:0] model_mem [256];
  int model_ptr;

  initial begin
    for (int k = 0; k < 6; k++) vecs[k] = '0;
    vecs[0].rd = 4'b1111; vecs[0].ra = {8'h03, 8'h02, 8'h01, 8'h00}; vecs[0].lat = 2; vecs[0].n = 4;
    vecs[0].exp[0] = ex(0, 0, 8'h99); vecs[0].exp[1] = ex(0, 1, 8'h98);
    vecs[0].exp[2] = ex(0, 2, 8'h9B); vecs[0].exp[3] = ex(0, 3, 8'h9A);
    vecs[1].rd = 4'b0100; vecs[1].ra[2] = 8'h3C; vecs[1].lat = 1; vecs[1].n = 1;
    vecs[1].exp[0] = ex(0, 2, 8'hA5);
    vecs[2].rd = 4'b1001; vecs[2].ra[0] = 8'h20; vecs[2].ra[3] = 8'h21; vecs[2].lat = 0; vecs[2].n = 2;
    vecs[2].exp[0] = ex(0, 3, 8'hB8); vecs[2].exp[1] = ex(0, 0, 8'hB9);
    vecs[3].wr = 4'b0010; vecs[3].wa[1] = 8'h10; vecs[3].wd[1] = 8'h55;
    vecs[3].rd = 4'b1000; vecs[3].ra[3] = 8'h10; vecs[3].lat = 1; vecs[3].n = 2;
    vecs[3].exp[0] = ex(1, 1, 8'h00); vecs[3].exp[1] = ex(0, 3, 8'h55);
    vecs[4].rd = 4'b0001; vecs[4].ra[0] = 8'h10; vecs[4].wr = 4'b0001; vecs[4].wa[0] = 8'h11;
    vecs[4].wd[0] = 8'h77; vecs[4].lat = 3; vecs[4].n = 2;
    vecs[4].exp[0] = ex(0, 0, 8'h55); vecs[4].exp[1] = ex(1, 0, 8'h00);
    vecs[5].rd = 4'b0011; vecs[5].ra[0] = 8'h11; vecs[5].ra[1] = 8'h12; vecs[5].lat = 0; vecs[5].n = 2;
    vecs[5].exp[0] = ex(0, 1, 8'h8B); vecs[5].exp[1] = ex(0, 0, 8'h77);

    // Reset state
    #12;
    chk("rst_mem_read_valid", 32'(mem_read_valid), 0);
    chk("rst_mem_write_valid", 32'(mem_write_valid), 0);
    chk("rst_mem_read_address", mem_read_address, 0);
    chk("rst_mem_write_bus", {mem_write_address, mem_write_data}, 0);
    chk("rst_read_ready", 32'(consumer_read_ready), 0);
    chk("rst_write_ready", 32'(consumer_write_ready), 0);
    chk("rst_read_data", consumer_read_data, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin
        cur_ra[i] = vecs[k].ra[i];
        cur_wa[i] = vecs[k].wa[i];
        cur_wd[i] = vecs[k].wd[i];
      end
      mem_lat = vecs[k].lat;
      exp_q.delete();
      for (int j = 0; j < vecs[k].n; j++) exp_q.push_back(vecs[k].exp[j]);
      run_batch(vecs[k].rd, vecs[k].wr);
      compare_q($sformatf("vec%0d", k));
    end

    // Single read timing: c2 reads 0x3C with one memory wait cycle
    mem_lat = 1;
    @(negedge clk);
    consumer_read_address[2*8 +: 8] = 8'h3C;
    consumer_read_valid = 4'b0100;
    @(negedge clk);
    chk("t1_mem_valid_plus1", 32'(mem_read_valid), 1);
    chk("t1_mem_addr", mem_read_address, 8'h3C);
    chk("t1_ready_early", 32'(consumer_read_ready), 0);
    consumer_read_address[2*8 +: 8] = 8'hFF;
    @(negedge clk);
    chk("t1_addr_held", mem_read_address, 8'h3C);
    chk("t1_ready_wait", 32'(consumer_read_ready), 0);
    @(negedge clk);
    chk("t1_ready", 32'(consumer_read_ready), 32'b0100);
    chk("t1_data", consumer_read_data[2*8 +: 8], 8'hA5);
    chk("t1_mem_valid_drop", 32'(mem_read_valid), 0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_ready_held", 32'(consumer_read_ready), 32'b0100);
    consumer_read_valid = '0;
    @(negedge clk);
    chk("t1_ready_release", 32'(consumer_read_ready), 0);

    // Reset asserted mid-cycle while a read is waiting on memory
    mem_lat = 6;
    @(negedge clk);
    consumer_read_address[2*8 +: 8] = 8'h44;
    consumer_read_valid = 4'b0100;
    for (int c = 0; c < 20 && !mem_read_valid; c++) @(negedge clk);
    chk("t4_granted", 32'(mem_read_valid), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t4_async_mem_valid", 32'(mem_read_valid), 0);
    chk("t4_async_mem_addr", mem_read_address, 0);
    chk("t4_async_ready", 32'(consumer_read_ready | consumer_write_ready), 0);
    chk("t4_async_data", consumer_read_data, 0);
    consumer_read_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mem_lat = 1;
    for (int i = 0; i < N; i++) begin
      cur_ra[i] = 8'h45 + 8'(i == 3);
      cur_wa[i] = 8'h00;
      cur_wd[i] = 8'h00;
    end
    exp_q.delete();
    exp_q.push_back(ex(0, 0, 8'hDC));
    exp_q.push_back(ex(0, 3, 8'hDF));
    run_batch(4'b1001, 4'b0000);
    compare_q("t4_after_reset");

    // Random batches against a round-robin service model
    for (int a = 0; a < 256; a++) model_mem[a] = 8'(a) ^ 8'h99;
    model_ptr = 0;
    for (int b = 0; b < 40; b++) begin
      logic [3:0] rd, wr, pend_rd, pend_wr;
      int j;
      rd = 4'($urandom);
      wr = 4'($urandom);
      if ((rd | wr) == 0) rd = 4'b0001;
      for (int i = 0; i < N; i++) begin
        cur_ra[i] = 8'h80 + 8'($urandom_range(0, 7));
        cur_wa[i] = 8'h80 + 8'($urandom_range(0, 7));
        cur_wd[i] = 8'($urandom);
      end
      mem_lat = $urandom_range(0, 3);
      exp_q.delete();
      pend_rd = rd;
      pend_wr = wr;
      while ((pend_rd | pend_wr) != 0) begin
        j = -1;
        for (int k = 0; k < N && j < 0; k++) begin
          if (pend_rd[(model_ptr + k) % N] || pend_wr[(model_ptr + k) % N]) j = (model_ptr + k) % N;
        end
        if (pend_rd[j]) begin
          exp_q.push_back(ex(0, j, model_mem[cur_ra[j]]));
          pend_rd[j] = 1'b0;
        end else begin
          model_mem[cur_wa[j]] = cur_wd[j];
          exp_q.push_back(ex(1, j, 8'h00));
          pend_wr[j] = 1'b0;
        end
        model_ptr = (j + 1) % N;
      end
      run_batch(rd, wr);
      compare_q($sformatf("rand%0d", b));
    end

    // Three consumers, no write path: c1 also holds a write that must be ignored
    b_cra = {8'h42, 8'h41, 8'h40};
    b_cwa = {8'h00, 8'h30, 8'h00};
    b_cwd = {8'h00, 8'hEE, 8'h00};
    b_cwv = 3'b010;
    b_order.delete();
    b_serve(3'b111);
    b_serve(3'b001);
    b_cwv = '0;
    chk("b_order_count", b_order.size(), 4);
    for (int k = 0; k < 4 && k < b_order.size(); k++) begin
      chk($sformatf("b_order%0d", k), b_order[k], (k == 3) ? 0 : k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
